// File: rtl/jtgng_rom_arbiter.sv
// ============================================================================
//  Module      : jtgng_rom_arbiter
//  Description : ROM fetch arbiter in front of the SDRAM read controller.
//                Four clients, each with a single cached 32-bit line. Misses
//                are arbitrated with fixed priority (client 0 highest) onto
//                one controller read port.
//                Build option: JTGNG_ROM_LINE2_EN reuses both halves of the
//                2-word burst. Without it, the tag is the full word address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtgng_rom_arbiter #(
    parameter int          AW      = 18,
    parameter logic [21:0] OFFSET0 = 22'h0,
    parameter logic [21:0] OFFSET1 = 22'h0,
    parameter logic [21:0] OFFSET2 = 22'h0,
    parameter logic [21:0] OFFSET3 = 22'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          loop_rst,
    input  logic          downloading,
    input  logic [3:0]    cs,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    output logic [15:0]   dout0,
    output logic [15:0]   dout1,
    output logic [15:0]   dout2,
    output logic [15:0]   dout3,
    output logic [3:0]    ok,
    output logic          read_sync,
    output logic          read_req,
    output logic [21:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [31:0]   data_read
);

`ifdef JTGNG_ROM_LINE2_EN
    localparam int c_TW = AW - 1;
`else
    localparam int c_TW = AW;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sel;
    logic [c_TW-1:0]   r_req_tag;
    logic [3:0]        r_valid;
    logic [31:0]       r_line [4];
    logic [c_TW-1:0]   r_tag  [4];

    logic [AW-1:0]     w_addr [4];
    logic [c_TW-1:0]   w_atag [4];
    logic [15:0]       w_dout [4];
    logic [3:0]        w_hit;
    logic [3:0]        w_miss;
    logic [1:0]        w_win;
    logic [21:0]       w_offset;
    logic [21:0]       w_base;

    assign w_addr[0] = addr0;
    assign w_addr[1] = addr1;
    assign w_addr[2] = addr2;
    assign w_addr[3] = addr3;

    // Per-client lookup: tag compare and word select from the cached line
    for (genvar n = 0; n < 4; n++) begin : g_client
`ifdef JTGNG_ROM_LINE2_EN
        assign w_atag[n] = w_addr[n][AW-1:1];
        assign w_dout[n] = w_addr[n][0] ? r_line[n][31:16] : r_line[n][15:0];
`else
        assign w_atag[n] = w_addr[n];
        assign w_dout[n] = r_line[n][15:0];
`endif
        assign w_hit[n]  = r_valid[n] && (r_tag[n] == w_atag[n]);
        assign w_miss[n] = cs[n] && !w_hit[n];
    end

`ifndef JTGNG_ROM_LINE2_EN
    // Upper burst word is stored but never served in single-word mode
    logic w_unused;
    assign w_unused = ^{r_line[0][31:16], r_line[1][31:16],
                        r_line[2][31:16], r_line[3][31:16]};
`endif

    assign dout0 = w_dout[0];
    assign dout1 = w_dout[1];
    assign dout2 = w_dout[2];
    assign dout3 = w_dout[3];
    assign ok    = cs & w_hit & {4{~downloading}};

    // Fixed-priority winner among pending misses, client 0 highest
    always_comb begin
        w_win = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (w_miss[n]) w_win = 2'(n);
        end
    end

    // SDRAM address of the winning client: base offset plus word address
    always_comb begin
        w_offset = OFFSET0;
        case (w_win)
            2'd1:    w_offset = OFFSET1;
            2'd2:    w_offset = OFFSET2;
            2'd3:    w_offset = OFFSET3;
            default: w_offset = OFFSET0;
        endcase
`ifdef JTGNG_ROM_LINE2_EN
        w_base = w_offset + {{(22-AW){1'b0}}, w_addr[w_win][AW-1:1], 1'b0};
`else
        w_base = w_offset + {{(22-AW){1'b0}}, w_addr[w_win]};
`endif
    end

    // Request FSM and cache fill; the download flag invalidates every line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'd0;
            r_req_tag  <= '0;
            r_valid    <= 4'd0;
            read_req   <= 1'b0;
            read_sync  <= 1'b0;
            sdram_addr <= 22'd0;
            for (int n = 0; n < 4; n++) begin
                r_line[n] <= 32'd0;
                r_tag[n]  <= '0;
            end
        end else begin
            if (downloading) r_valid <= 4'd0;
            case (r_state)
                S_IDLE: begin
                    if (!loop_rst && !downloading && (|w_miss)) begin
                        r_sel      <= w_win;
                        r_req_tag  <= w_atag[w_win];
                        sdram_addr <= w_base;
                        read_req   <= 1'b1;
                        read_sync  <= ~read_sync;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sdram_ack) begin
                        read_req <= 1'b0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_rdy) begin
                        r_line[r_sel] <= data_read;
                        r_tag[r_sel]  <= r_req_tag;
                        if (!downloading) r_valid[r_sel] <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtgng_rom_arbiter.sv
// ============================================================================
//  Module      : tb_jtgng_rom_arbiter
//  Description : Self-checking bench for jtgng_rom_arbiter. A table of
//                single-client fetches followed by directed sequences for
//                priority, address change in flight, download, loop reset
//                and reset during a pending fill.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtgng_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        loop_rst = 1'b0;
    logic        downloading = 1'b0;
    logic [3:0]  cs = 4'd0;
    logic [17:0] addr0 = '0, addr1 = '0, addr2 = '0, addr3 = '0;
    logic [15:0] dout0, dout1, dout2, dout3;
    logic [3:0]  ok;
    logic        read_sync, read_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        data_rdy = 1'b0;
    logic [31:0] data_read = 32'd0;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_sync = 1'b0;

    jtgng_rom_arbiter #(
        .AW(18), .OFFSET0(22'h0), .OFFSET1(22'h0),
        .OFFSET2(22'h0), .OFFSET3(22'h200000)
    ) dut (
        .clk(clk), .rst(rst), .loop_rst(loop_rst), .downloading(downloading),
        .cs(cs), .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .ok(ok), .read_sync(read_sync), .read_req(read_req),
        .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          client;
        logic [17:0] addr;
        logic [31:0] data;
        logic        req;
        logic [21:0] exp_sa;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] dout_of(input int c);
        case (c)
            0: return dout0;
            1: return dout1;
            2: return dout2;
            default: return dout3;
        endcase
    endfunction

    task automatic set_addr(input int c, input logic [17:0] a);
        case (c)
            0: addr0 = a;
            1: addr1 = a;
            2: addr2 = a;
            default: addr3 = a;
        endcase
    endtask

    // Wait (bounded) for read_req at a negedge, then check address and toggle
    task automatic wait_req(input logic [21:0] exp_sa);
        int n = 0;
        while (!read_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", read_req, 1'b1);
        chk("sdram_addr", sdram_addr, exp_sa);
        exp_sync = ~exp_sync;
        chk("read_sync", read_sync, exp_sync);
    endtask

    // Controller side: ack now, data four cycles after the ack
    task automatic finish_fill(input logic [31:0] data);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk("req_drop", read_req, 1'b0);
        repeat (3) @(negedge clk);
        data_read = data;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
    endtask

    task automatic do_fill(input logic [21:0] exp_sa, input logic [31:0] data);
        wait_req(exp_sa);
        finish_fill(data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef JTGNG_ROM_LINE2_EN
        vecs[0] = '{0, 18'h00100, 32'hBEEF_CAFE, 1'b1, 22'h000100, 16'hCAFE};
        vecs[1] = '{0, 18'h00101, 32'h1234_5678, 1'b0, 22'h000000, 16'hBEEF};
        vecs[2] = '{1, 18'h3FFFF, 32'hAAAA_5555, 1'b1, 22'h03FFFE, 16'hAAAA};
        vecs[3] = '{2, 18'h00007, 32'h0F0F_F0F0, 1'b1, 22'h000006, 16'h0F0F};
        vecs[4] = '{3, 18'h3FFFF, 32'h1111_2222, 1'b1, 22'h23FFFE, 16'h1111};
`else
        vecs[0] = '{0, 18'h00100, 32'hBEEF_CAFE, 1'b1, 22'h000100, 16'hCAFE};
        vecs[1] = '{0, 18'h00101, 32'h1234_5678, 1'b1, 22'h000101, 16'h5678};
        vecs[2] = '{1, 18'h3FFFF, 32'hAAAA_5555, 1'b1, 22'h03FFFF, 16'h5555};
        vecs[3] = '{2, 18'h00007, 32'h0F0F_F0F0, 1'b1, 22'h000007, 16'hF0F0};
        vecs[4] = '{3, 18'h3FFFF, 32'h1111_2222, 1'b1, 22'h23FFFF, 16'h2222};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_read_req", read_req, 1'b0);
        chk("rst_read_sync", read_sync, 1'b0);
        chk("rst_sdram_addr", sdram_addr, 22'd0);
        chk("rst_ok", ok, 4'd0);
        chk("rst_dout0", dout0, 16'd0);

        // Table of single-client fetches
        for (int i = 0; i < 5; i++) begin
            cs = 4'd0;
            cs[vecs[i].client] = 1'b1;
            set_addr(vecs[i].client, vecs[i].addr);
            #1;
            if (vecs[i].req) begin
                chk("vec_ok_before", ok[vecs[i].client], 1'b0);
                do_fill(vecs[i].exp_sa, vecs[i].data);
                chk("vec_ok_after", ok[vecs[i].client], 1'b1);
                chk("vec_dout", dout_of(vecs[i].client), vecs[i].exp_dout);
            end else begin
                chk("vec_hit_ok", ok[vecs[i].client], 1'b1);
                chk("vec_hit_dout", dout_of(vecs[i].client), vecs[i].exp_dout);
                repeat (3) begin
                    @(negedge clk);
                    chk("vec_hit_noreq", read_req, 1'b0);
                    chk("vec_hit_nosync", read_sync, exp_sync);
                end
            end
            @(negedge clk);
        end

        // Clients 1 and 3 miss together: client 1 first
        cs = 4'b1010;
        addr1 = 18'h00050;
        addr3 = 18'h00004;
        do_fill(22'h000050, 32'h5151_5050);
        chk("prio_ok1", ok[1], 1'b1);
        chk("prio_ok3_pending", ok[3], 1'b0);
        chk("prio_dout1", dout1, 16'h5050);
        do_fill(22'h200004, 32'h3333_4444);
        chk("prio_ok3", ok[3], 1'b1);
        chk("prio_dout3", dout3, 16'h4444);

        // Address change while waiting for data
        @(negedge clk);
        cs = 4'b0100;
        addr2 = 18'h00010;
        wait_req(22'h000010);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        addr2 = 18'h00020;
        repeat (3) @(negedge clk);
        data_read = 32'h0000_0010;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
        #1;
        chk("chg_ok2_low", ok[2], 1'b0);
        @(negedge clk);
        wait_req(22'h000020);
        addr2 = 18'h00010;
        #1;
        chk("chg_old_tag_hit", ok[2], 1'b1);
        chk("chg_old_dout", dout2, 16'h0010);
        addr2 = 18'h00020;
        finish_fill(32'h2020_2121);
        chk("chg_ok2", ok[2], 1'b1);
        chk("chg_dout2", dout2, 16'h2121);

        // Download pulse invalidates every line
        cs = 4'b1111;
        #1;
        chk("dl_all_ok", ok, 4'b1111);
        downloading = 1'b1;
        #1;
        chk("dl_ok_low", ok, 4'd0);
        repeat (5) begin
            @(negedge clk);
            chk("dl_noreq", read_req, 1'b0);
        end
        downloading = 1'b0;
        #1;
        chk("dl_after_ok", ok, 4'd0);
`ifdef JTGNG_ROM_LINE2_EN
        do_fill(22'h000100, 32'hA0A1_A0A0);
`else
        do_fill(22'h000101, 32'hA0A1_A0A0);
`endif
        do_fill(22'h000050, 32'h0000_5A5A);
        do_fill(22'h000020, 32'h2020_2121);
        do_fill(22'h200004, 32'h3333_4444);
        chk("dl_refetch_ok", ok, 4'b1111);
        chk("dl_dout1", dout1, 16'h5A5A);

        // loop_rst holds off a pending miss
        @(negedge clk);
        loop_rst = 1'b1;
        cs = 4'b0001;
        addr0 = 18'h00200;
        repeat (4) begin
            @(negedge clk);
            chk("lr_noreq", read_req, 1'b0);
        end
        loop_rst = 1'b0;
        @(negedge clk);
        chk("lr_req_next", read_req, 1'b1);
        do_fill(22'h000200, 32'h0000_0200);
        chk("lr_ok0", ok[0], 1'b1);

        // Reset while waiting for data, then a stray data_rdy
        @(negedge clk);
        addr0 = 18'h00300;
        wait_req(22'h000300);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        rst = 1'b1;
        exp_sync = 1'b0;
        #1;
        chk("rw_read_req", read_req, 1'b0);
        chk("rw_read_sync", read_sync, 1'b0);
        chk("rw_sdram_addr", sdram_addr, 22'd0);
        chk("rw_ok", ok, 4'd0);
        chk("rw_dout0", dout0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        cs = 4'd0;
        @(negedge clk);
        data_read = 32'hFFFF_FFFF;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
        cs = 4'b0001;
        #1;
        chk("rw_stray_ok", ok[0], 1'b0);
        chk("rw_stray_dout", dout0, 16'd0);
        chk("rw_stray_req", read_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
